// File: rtl/dot_product_acc_if.sv
// Bus bundle for dot_product_acc: lane results and op tag in, result bank and status out.
// in_valid qualifies pe_res/shift for one cycle and has no ready: every valid beat is taken; wr_valid is a one-cycle pulse qualifying wr_idx.
interface dot_product_acc_if #(
  parameter int PE_COUNT   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_DEPTH  = 4
);
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] pe_res;
  logic                                in_valid;
  logic                                shift;
  logic                                clear;
  logic [OUT_DEPTH-1:0][ACC_WIDTH-1:0] dot_out;
  logic                                wr_valid;
  logic [$clog2(OUT_DEPTH)-1:0]        wr_idx;
  logic                                full;
  logic                                ovf;
  logic                                busy;

  modport master (
    output pe_res, in_valid, shift, clear,
    input  dot_out, wr_valid, wr_idx, full, ovf, busy
  );

  modport slave (
    input  pe_res, in_valid, shift, clear,
    output dot_out, wr_valid, wr_idx, full, ovf, busy
  );
endinterface

// File: rtl/dot_product_acc.sv
// Registered adder-tree reduction of PE lane results feeding a saturating
// accumulate / shift-into-next-slot result bank.
module dot_product_acc #(
  parameter int PE_COUNT   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rstn,
  dot_product_acc_if.slave bus
);
  localparam int L  = $clog2(PE_COUNT);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int NN = PE_COUNT - 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [PW:0]          FULL_CNT = (PW+1)'(OUT_DEPTH);

  logic [ACC_WIDTH-1:0] lane_ext [PE_COUNT];
  logic [ACC_WIDTH-1:0] node_d   [NN];
  logic [ACC_WIDTH-1:0] node_q   [NN];
  logic [L-1:0]         vld_q;
  logic [L-1:0]         shf_q;

  for (genvar j = 0; j < PE_COUNT; j++) begin : g_lane
    assign lane_ext[j] = {{(ACC_WIDTH-DATA_WIDTH){bus.pe_res[j][DATA_WIDTH-1]}}, bus.pe_res[j]};
  end

  // Heap-ordered tree: node i sums children 2i+1 / 2i+2; indices >= NN are lanes.
  // Every internal node is a register, so a balanced tree gives exactly L stages.
  for (genvar i = 0; i < NN; i++) begin : g_node
    logic [ACC_WIDTH-1:0] lhs;
    logic [ACC_WIDTH-1:0] rhs;
    if (2*i+1 < NN) begin : g_inner
      assign lhs = node_q[2*i+1];
      assign rhs = node_q[2*i+2];
    end else begin : g_leaf
      assign lhs = lane_ext[2*i+1-NN];
      assign rhs = lane_ext[2*i+2-NN];
    end
    assign node_d[i] = lhs + rhs;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NN; k++) node_q[k] <= '0;
    end else begin
      for (int k = 0; k < NN; k++) node_q[k] <= node_d[k];
    end
  end

  // Op tag travels beside the data; clear kills everything in flight.
  always_ff @(posedge clk) begin
    if (!rstn || bus.clear) begin
      vld_q <= '0;
      shf_q <= '0;
    end else begin
      vld_q[0] <= bus.in_valid;
      shf_q[0] <= bus.shift;
      for (int k = 1; k < L; k++) begin
        vld_q[k] <= vld_q[k-1];
        shf_q[k] <= shf_q[k-1];
      end
    end
  end

  logic                                wb_valid;
  logic                                wb_shift;
  logic [ACC_WIDTH-1:0]                wb_sum;
  logic [OUT_DEPTH-1:0][ACC_WIDTH-1:0] bank_q;
  logic [PW-1:0]                       ptr_q;
  logic [PW-1:0]                       tgt;
  logic [PW:0]                         cnt_q;
  logic                                ovf_q;
  logic                                wr_valid_q;
  logic [PW-1:0]                       wr_idx_q;
  logic [ACC_WIDTH-1:0]                cur;
  logic [ACC_WIDTH:0]                  acc_wide;
  logic [ACC_WIDTH-1:0]                wb_val;
  logic                                sat;

  assign wb_valid = vld_q[L-1];
  assign wb_shift = shf_q[L-1];
  assign wb_sum   = node_q[0];

  // Single read-modify-write stage: the bank read always sees the previous op's result.
  always_comb begin
    tgt      = wb_shift ? ptr_q + PW'(1) : ptr_q;
    cur      = bank_q[ptr_q];
    acc_wide = {cur[ACC_WIDTH-1], cur} + {wb_sum[ACC_WIDTH-1], wb_sum};
    sat      = acc_wide[ACC_WIDTH] != acc_wide[ACC_WIDTH-1];
    wb_val   = wb_sum;
    if (!wb_shift) begin
      if (sat) wb_val = acc_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      else     wb_val = acc_wide[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || bus.clear) begin
      bank_q     <= '0;
      ptr_q      <= '1;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_idx_q   <= '0;
    end else begin
      wr_valid_q <= wb_valid;
      if (wb_valid) begin
        bank_q[tgt] <= wb_val;
        ptr_q       <= tgt;
        wr_idx_q    <= tgt;
        if (wb_shift && cnt_q != FULL_CNT) cnt_q <= cnt_q + 1'b1;
        if (!wb_shift && sat)              ovf_q <= 1'b1;
      end
    end
  end

  assign bus.dot_out  = bank_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_idx   = wr_idx_q;
  assign bus.full     = (cnt_q == FULL_CNT);
  assign bus.ovf      = ovf_q;
  assign bus.busy     = |vld_q;
endmodule

// File: tb/tb_dot_product_acc.sv
// Randomized scoreboard bench for dot_product_acc (PE_COUNT=4, DATA_WIDTH=16, ACC_WIDTH=20, OUT_DEPTH=4).
module tb_dot_product_acc;
  localparam int PE = 4, DW = 16, AW = 20, OD = 4;
  localparam longint MAXV = 524287;
  localparam longint MINV = -524288;

  typedef logic [PE-1:0][DW-1:0] lanes_t;
  typedef struct packed {
    logic [31:0]           cyc;
    logic [1:0]            idx;
    logic [OD-1:0][AW-1:0] bank;
    logic                  full;
    logic                  ovf;
  } exp_t;

  logic clk;
  logic rstn;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   mon_en = 0;

  exp_t exp_q[$];
  logic [OD-1:0][AW-1:0] com_bank;
  logic com_full, com_ovf;

  longint m_bank[OD];
  int     m_ptr, m_cnt;
  bit     m_ovf;

  dot_product_acc_if #(.PE_COUNT(PE), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_DEPTH(OD)) bus ();

  dot_product_acc #(.PE_COUNT(PE), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_DEPTH(OD)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // reference model: slot bank with a pointer, evaluated in program order at issue time
  task automatic model_reset();
    for (int i = 0; i < OD; i++) m_bank[i] = 0;
    m_ptr = OD - 1;
    m_cnt = 0;
    m_ovf = 0;
    exp_q.delete();
    com_bank = '0;
    com_full = 1'b0;
    com_ovf  = 1'b0;
  endtask

  task automatic model_issue(input lanes_t l, input bit sh);
    longint s = 0;
    longint v;
    exp_t e;
    for (int i = 0; i < PE; i++) s += longint'($signed(l[i]));
    if (sh) begin
      m_ptr = (m_ptr + 1) % OD;
      v = s;
      if (m_cnt < OD) m_cnt++;
    end else begin
      v = m_bank[m_ptr] + s;
      if (v > MAXV) begin v = MAXV; m_ovf = 1; end
      else if (v < MINV) begin v = MINV; m_ovf = 1; end
    end
    m_bank[m_ptr] = v;
    e.cyc  = 32'(cyc + 3);
    e.idx  = 2'(m_ptr);
    for (int i = 0; i < OD; i++) e.bank[i] = AW'(m_bank[i]);
    e.full = (m_cnt == OD);
    e.ovf  = m_ovf;
    exp_q.push_back(e);
  endtask

  // driver tasks (entered and left at posedge + #1)
  task automatic send(input lanes_t l, input bit sh);
    bus.pe_res   = l;
    bus.in_valid = 1'b1;
    bus.shift    = sh;
    model_issue(l, sh);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input bit iv);
    bus.clear    = 1'b1;
    bus.in_valid = iv;
    bus.shift    = 1'($urandom_range(0, 1));
    bus.pe_res   = lanes_t'({$urandom, $urandom});
    @(posedge clk); #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
  endtask

  function automatic lanes_t rand_lanes();
    lanes_t l;
    for (int i = 0; i < PE; i++) begin
      case ($urandom_range(0, 3))
        0:       l[i] = 16'h7FFF;
        1:       l[i] = 16'h8000;
        default: l[i] = 16'($urandom);
      endcase
    end
    return l;
  endfunction

  // monitor / scoreboard
  bit   want_wr;
  bit   busy_exp;
  exp_t got_e;
  always @(negedge clk) begin
    if (rstn && mon_en) begin
      want_wr = (exp_q.size() > 0) && (exp_q[0].cyc == 32'(cyc));
      check("wr_valid", 128'(bus.wr_valid), 128'(want_wr));
      if (want_wr) begin
        got_e = exp_q.pop_front();
        if (bus.wr_valid) begin
          check("wr_idx", 128'(bus.wr_idx), 128'(got_e.idx));
          check("wr_bank", 128'(bus.dot_out), 128'(got_e.bank));
          check("wr_full", 128'(bus.full), 128'(got_e.full));
          check("wr_ovf", 128'(bus.ovf), 128'(got_e.ovf));
        end
        com_bank = got_e.bank;
        com_full = got_e.full;
        com_ovf  = got_e.ovf;
      end else begin
        check("hold_bank", 128'(bus.dot_out), 128'(com_bank));
        check("hold_full", 128'(bus.full), 128'(com_full));
        check("hold_ovf", 128'(bus.ovf), 128'(com_ovf));
      end
      busy_exp = 1'b0;
      foreach (exp_q[i]) if (exp_q[i].cyc <= 32'(cyc + 2)) busy_exp = 1'b1;
      check("busy", 128'(bus.busy), 128'(busy_exp));
    end
  end

  // stimulus
  initial begin
    bus.pe_res   = '0;
    bus.in_valid = 1'b0;
    bus.shift    = 1'b0;
    bus.clear    = 1'b0;
    rstn         = 1'b0;
    do_reset();
    check("rst_dot_out", 128'(bus.dot_out), 128'(0));
    check("rst_wr_valid", 128'(bus.wr_valid), 128'(0));
    check("rst_wr_idx", 128'(bus.wr_idx), 128'(0));
    check("rst_full", 128'(bus.full), 128'(0));
    check("rst_ovf", 128'(bus.ovf), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    mon_en = 1;

    // basic shift then back-to-back accumulates: 10, 6, 2, -2
    send({16'd4, 16'd3, 16'd2, 16'd1}, 1'b1);
    repeat (3) send({4{16'hFFFF}}, 1'b0);
    idle(3);
    check("basic_slot0", 128'(bus.dot_out[0]), 128'(20'hFFFFE));
    check("basic_ovf", 128'(bus.ovf), 128'(0));

    // saturation into slot 1, then a shift leaves ovf set
    send({4{16'h7FFF}}, 1'b1);
    repeat (4) send({4{16'h7FFF}}, 1'b0);
    send('0, 1'b1);
    idle(3);
    check("sat_slot1", 128'(bus.dot_out[1]), 128'(20'h7FFFF));
    check("sat_ovf", 128'(bus.ovf), 128'(1));
    check("sat_slot2", 128'(bus.dot_out[2]), 128'(0));

    // wrap-around and full
    do_clear(1'b0);
    for (int k = 1; k <= 5; k++) send({16'd0, 16'd0, 16'd0, 16'(k)}, 1'b1);
    idle(3);
    check("wrap_bank", 128'(bus.dot_out), 128'({20'd4, 20'd3, 20'd2, 20'd5}));
    check("wrap_full", 128'(bus.full), 128'(1));

    // clear while an op is in the tree
    send({4{16'd5}}, 1'b1);
    do_clear(1'b0);
    check("clr_busy", 128'(bus.busy), 128'(0));
    check("clr_dot_out", 128'(bus.dot_out), 128'(0));
    idle(3);
    check("clr_no_write", 128'(bus.dot_out), 128'(0));
    send({16'd0, 16'd0, 16'd0, 16'd7}, 1'b1);
    idle(3);
    check("clr_next_slot0", 128'(bus.dot_out[0]), 128'(7));

    // random traffic with occasional clears (some carrying a dropped in_valid)
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3)       do_clear(1'($urandom_range(0, 1)));
      else if (r < 15) idle(1);
      else             send(rand_lanes(), $urandom_range(0, 2) == 0);
    end

    idle(6);
    check("drain", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
